pyr_downsample: RTL



---
 rtl/pyr_pkg.sv | 14 +
 rtl/pyr_beat_decimate.sv | 27 ++
 rtl/pyr_downsample.sv | 118 +++++++++++
 3 files changed

// File: rtl/pyr_pkg.sv
// Shared constants and helpers for the image pyramid stages.
package pyr_pkg;

    localparam int PIX_W           = 8;
    localparam int PIXELS_PER_BEAT = 16;
    localparam int IMAGE_DIM       = 512;
    localparam int COL_MAX         = IMAGE_DIM / PIXELS_PER_BEAT;

    // Frame width/height in pixels at a given pyramid level (level 0 = full size).
    function automatic int dim_at_level(input int level);
        return IMAGE_DIM >> level;
    endfunction

endpackage

// File: rtl/pyr_beat_decimate.sv
// Even-pixel extraction: pixel 2k of a beat becomes pixel k of the half-beat.
// Kept separate so the expand stage can share the same lane mapping.
module pyr_beat_decimate #(
    parameter int PIXELS_PER_BEAT = pyr_pkg::PIXELS_PER_BEAT
) (
    input  logic [pyr_pkg::PIX_W*PIXELS_PER_BEAT-1:0]   beat_in,
    output logic [pyr_pkg::PIX_W*PIXELS_PER_BEAT/2-1:0] half_out
);
    import pyr_pkg::*;

    localparam int HALF_PIX = PIXELS_PER_BEAT / 2;

    // Odd pixels are deliberately dropped; they are folded into a parity
    // signal only so every input bit has a reader.
    logic [PIX_W-1:0] unused_odd;

    // Select even lanes into the packed half-beat.
    always_comb begin
        half_out   = '0;
        unused_odd = '0;
        for (int k = 0; k < HALF_PIX; k++) begin
            half_out[PIX_W*k +: PIX_W] = beat_in[2*PIX_W*k +: PIX_W];
            unused_odd                 = unused_odd ^ beat_in[(2*k+1)*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/pyr_downsample.sv
// Pyramid REDUCE decimator: keeps even rows / even columns of the blurred
// stream and packs two decimated half-beats into one output beat.
module pyr_downsample #(
    parameter int PIXELS_PER_BEAT = pyr_pkg::PIXELS_PER_BEAT,
    parameter int IMAGE_DIM       = pyr_pkg::IMAGE_DIM,
    parameter int DATA_WIDTH      = pyr_pkg::PIX_W * PIXELS_PER_BEAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_frame,
    output logic                  out_valid,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic [DATA_WIDTH-1:0] out_frame
);
    import pyr_pkg::*;

    localparam int COLS   = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(IMAGE_DIM);
    localparam int HALF_W = DATA_WIDTH / 2;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_DIM - 1);
    localparam logic [RW-1:0] ROW_EOF  = RW'(IMAGE_DIM - 2);

    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [RW-1:0]         row_cnt_q, row_cnt_d;
    logic [HALF_W-1:0]     hold_q, hold_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_eol_q, out_eol_d;
    logic                  out_eof_q, out_eof_d;
    logic [DATA_WIDTH-1:0] out_frame_q, out_frame_d;

    logic [HALF_W-1:0]     half;
    logic                  accept;
    logic [CW-1:0]         eff_col;
    logic [RW-1:0]         eff_row;
    logic                  kept_row;

    pyr_beat_decimate #(
        .PIXELS_PER_BEAT (PIXELS_PER_BEAT)
    ) u_decimate (
        .beat_in  (in_frame),
        .half_out (half)
    );

    // Position tracking, hold capture and output packing for the accepted beat.
    // in_sof overrides the counters so the beat is always row 0 / col 0; since
    // col 0 is even, a sof beat simply overwrites any pending hold half.
    always_comb begin
        accept   = in_valid & ~stall;
        eff_col  = in_sof ? '0 : col_cnt_q;
        eff_row  = in_sof ? '0 : row_cnt_q;
        kept_row = ~eff_row[0];

        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        out_frame_d = out_frame_q;

        if (accept) begin
            if (eff_col == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_cnt_d = eff_col + 1'b1;
                row_cnt_d = eff_row;
            end
            if (kept_row && !eff_col[0]) begin
                hold_d = half;
            end
        end

        // Outputs only move on unstalled cycles, so a stalled beat is held.
        if (!stall) begin
            out_valid_d = accept & kept_row & eff_col[0];
            out_eol_d   = out_valid_d & (eff_col == COL_LAST);
            out_eof_d   = out_eol_d & (eff_row == ROW_EOF);
            if (out_valid_d) begin
                out_frame_d = {half, hold_q};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_frame_q <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            out_frame_q <= out_frame_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign out_frame = out_frame_q;

endmodule
